// File: rtl/song_sequencer_pkg.sv
// Shared widths, ROM word layout, end-of-song marker and FSM state encoding for the
// song sequencer and its ROM.
package song_sequencer_pkg;

    localparam int unsigned SONG_W = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned ADDR_W = SONG_W + IDX_W;
    localparam int unsigned WORD_W = NOTE_W + DUR_W;

    // A zero duration marks the end of a song; note_player treats it the same way.
    localparam logic [DUR_W-1:0] END_MARKER_DUR = '0;
    localparam logic [IDX_W-1:0] LAST_IDX       = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitRom,
        StPlaying,
        StPaused,
        StDone
    } state_e;

    function automatic logic [WORD_W-1:0] pack_entry(input logic [NOTE_W-1:0] note,
                                                     input logic [DUR_W-1:0]  dur);
        return {note, dur};
    endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Synchronous song ROM: {note, duration} words addressed by {song, idx}, one-cycle read.
module song_rom
    import song_sequencer_pkg::*;
(
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [WORD_W-1:0] data_o
);

    logic [SONG_W-1:0] song;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] data_q;

    assign song = addr_i[ADDR_W-1:IDX_W];
    assign idx  = addr_i[IDX_W-1:0];

    // Unlisted slots read as end markers.
    always_comb begin
        word = pack_entry('0, END_MARKER_DUR);
        case (song)
            2'd0: begin
                case (idx)
                    5'd0:    word = pack_entry(6'd5, 6'd1);
                    5'd1:    word = pack_entry(6'd7, 6'd2);
                    5'd2:    word = pack_entry(6'd9, 6'd3);
                    default: ;
                endcase
            end
            2'd1: begin
                case (idx)
                    5'd0:    word = pack_entry(6'd12, 6'd4);
                    5'd1:    word = pack_entry(6'd20, 6'd2);
                    default: ;
                endcase
            end
            2'd2: begin
                case (idx)
                    5'd0:    word = pack_entry(6'd30, 6'd3);
                    5'd1:    word = pack_entry(6'd31, 6'd1);
                    5'd2:    word = pack_entry(6'd32, 6'd5);
                    5'd3:    word = pack_entry(6'd33, 6'd2);
                    default: ;
                endcase
            end
            // Song 3 fills all 32 slots, so it ends on the last index rather than a marker.
            default: word = pack_entry({1'b1, idx}, {4'b0, idx[1:0]} + 6'd1);
        endcase
    end

    always_ff @(posedge clk_i) begin
        data_q <= word;
    end

    assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks a song in the ROM, hands each {note, duration} to note_player with a new_note
// pulse, waits for note_done, and flags song_done at the end marker or the last slot.
module song_sequencer
    import song_sequencer_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              play_i,
    input  logic [SONG_W-1:0] song_i,
    input  logic              note_done_i,
    output logic [NOTE_W-1:0] note_to_load_o,
    output logic [DUR_W-1:0]  duration_to_load_o,
    output logic              new_note_o,
    output logic              song_done_o,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              new_note_q, new_note_d;
    logic              song_done_q, song_done_d;

    logic [WORD_W-1:0] rom_data;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              busy;

    song_rom u_rom (
        .clk_i  (clk_i),
        .addr_i ({song_q, idx_q}),
        .data_o (rom_data)
    );

    assign rom_note = rom_data[WORD_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];
    assign busy     = (state_q != StIdle) && (state_q != StDone);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        song_d      = song_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        // A song change restarts from slot 0 ahead of pause and note_done handling.
        if (busy && (song_i != song_q)) begin
            song_d  = song_i;
            idx_d   = '0;
            state_d = StFetch;
        end else begin
            case (state_q)
                StIdle: begin
                    if (play_i) begin
                        song_d  = song_i;
                        idx_d   = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    state_d = play_i ? StWaitRom : StPaused;
                end
                StWaitRom: begin
                    if (!play_i) begin
                        state_d = StPaused;
                    end else if (rom_dur == END_MARKER_DUR) begin
                        song_done_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        note_d     = rom_note;
                        dur_d      = rom_dur;
                        new_note_d = 1'b1;
                        state_d    = StPlaying;
                    end
                end
                StPlaying: begin
                    // note_done coinciding with the load pulse belongs to the old note.
                    if (!play_i) begin
                        state_d = StPaused;
                    end else if (note_done_i && !new_note_q) begin
                        if (idx_q == LAST_IDX) begin
                            song_done_d = 1'b1;
                            state_d     = StDone;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StFetch;
                        end
                    end
                end
                StPaused: begin
                    if (play_i) begin
                        state_d = StFetch;
                    end
                end
                StDone: begin
                    if (!play_i || (song_i != song_q)) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            song_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            song_q      <= song_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign note_to_load_o     = note_q;
    assign duration_to_load_o = dur_q;
    assign new_note_o         = new_note_q;
    assign song_done_o        = song_done_q;
    assign busy_o             = busy;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed scenarios plus randomized play/pause
// sessions checked against a song-table model of the ROM contents.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       note_done = 1'b0;
    logic [5:0] note_o;
    logic [5:0] dur_o;
    logic       new_note;
    logic       song_done;
    logic       busy;

    int checks = 0;
    int failures = 0;
    logic prev_nn = 1'b0;
    logic prev_sd = 1'b0;

    always #5 clk = ~clk;

    song_sequencer dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .play_i             (play),
        .song_i             (song),
        .note_done_i        (note_done),
        .note_to_load_o     (note_o),
        .duration_to_load_o (dur_o),
        .new_note_o         (new_note),
        .song_done_o        (song_done),
        .busy_o             (busy)
    );

    // Song table: number of real notes per song, then note/duration per slot.
    function automatic int ref_len(input int s);
        case (s)
            0:       return 3;
            1:       return 2;
            2:       return 4;
            default: return 32;
        endcase
    endfunction

    function automatic int ref_note(input int s, input int i);
        if (i >= ref_len(s)) return 0;
        case (s)
            0:       return 5 + 2 * i;
            1:       return (i == 0) ? 12 : 20;
            2:       return 30 + i;
            default: return 32 + i;
        endcase
    endfunction

    function automatic int ref_dur(input int s, input int i);
        if (i >= ref_len(s)) return 0;
        case (s)
            0:       return i + 1;
            1:       return (i == 0) ? 4 : 2;
            2:       return (i == 0) ? 3 : (i == 1) ? 1 : (i == 2) ? 5 : 2;
            default: return (i % 4) + 1;
        endcase
    endfunction

    // Pulses are one cycle wide and never overlap.
    always @(negedge clk) begin
        if (reset) begin
            prev_nn <= 1'b0;
            prev_sd <= 1'b0;
        end else begin
            checks++;
            if (new_note && song_done) begin
                failures++;
                $display("FAIL pulse_overlap: got both high, want at most one");
            end
            checks++;
            if ((new_note && prev_nn) || (song_done && prev_sd)) begin
                failures++;
                $display("FAIL pulse_width: got pulse longer than 1 cycle, want 1");
            end
            prev_nn <= new_note;
            prev_sd <= song_done;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for new_note (or song_done) and returns the cycle count; -1 on timeout.
    task automatic wait_pulse(input bit want_done, input int budget, output int lat,
                              output int other);
        lat   = -1;
        other = 0;
        for (int c = 1; c <= budget && lat < 0; c++) begin
            @(negedge clk);
            note_done = 1'b0;
            if (want_done ? song_done : new_note) lat = c;
            else if (want_done ? new_note : song_done) other++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        play  = 1'b0;
        tick();
        checks++; if (new_note !== 1'b0) begin failures++; $display("FAIL reset_new_note: got %0b want 0", new_note); end
        checks++; if (song_done !== 1'b0) begin failures++; $display("FAIL reset_song_done: got %0b want 0", song_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (note_o !== 6'd0) begin failures++; $display("FAIL reset_note: got %0d want 0", note_o); end
        checks++; if (dur_o !== 6'd0) begin failures++; $display("FAIL reset_dur: got %0d want 0", dur_o); end
        reset = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_two_note_song();
        int lat, oth;
        song = 2'd1;
        play = 1'b1;
        wait_pulse(0, 8, lat, oth);
        checks++; if (lat != 3) begin failures++; $display("FAIL t2_start_latency: got %0d want 3", lat); end
        checks++; if (note_o !== 6'd12 || dur_o !== 6'd4) begin failures++; $display("FAIL t2_entry0: got %0d/%0d want 12/4", note_o, dur_o); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t2_busy: got %0b want 1", busy); end
        tick();
        tick();
        note_done = 1'b1;
        wait_pulse(0, 8, lat, oth);
        checks++; if (lat != 3) begin failures++; $display("FAIL t2_next_latency: got %0d want 3", lat); end
        checks++; if (note_o !== 6'd20 || dur_o !== 6'd2) begin failures++; $display("FAIL t2_entry1: got %0d/%0d want 20/2", note_o, dur_o); end
        tick();
        note_done = 1'b1;
        wait_pulse(1, 8, lat, oth);
        checks++; if (lat != 3) begin failures++; $display("FAIL t2_done_latency: got %0d want 3", lat); end
        checks++; if (oth != 0) begin failures++; $display("FAIL t2_no_third_note: got %0d want 0", oth); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_done_busy: got %0b want 0", busy); end
        checks++; if (note_o !== 6'd20 || dur_o !== 6'd2) begin failures++; $display("FAIL t2_hold: got %0d/%0d want 20/2", note_o, dur_o); end
        play = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_pause_resume();
        int lat, oth, seen;
        song = 2'd1;
        play = 1'b1;
        wait_pulse(0, 8, lat, oth);
        tick();
        note_done = 1'b1;
        wait_pulse(0, 8, lat, oth);
        checks++; if (note_o !== 6'd20) begin failures++; $display("FAIL t3_at_idx1: got %0d want 20", note_o); end
        tick();
        play = 1'b0;
        tick();
        note_done = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            note_done = 1'b0;
            if (new_note || song_done) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL t3_quiet_pause: got %0d pulses want 0", seen); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t3_pause_busy: got %0b want 1", busy); end
        play = 1'b1;
        wait_pulse(0, 8, lat, oth);
        checks++; if (lat != 3) begin failures++; $display("FAIL t3_resume_latency: got %0d want 3", lat); end
        checks++; if (note_o !== 6'd20 || dur_o !== 6'd2) begin failures++; $display("FAIL t3_resume_entry: got %0d/%0d want 20/2", note_o, dur_o); end
        tick();
        note_done = 1'b1;
        wait_pulse(1, 8, lat, oth);
        checks++; if (lat != 3) begin failures++; $display("FAIL t3_done_latency: got %0d want 3", lat); end
        play = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_song_change();
        int lat, oth;
        song = 2'd1;
        play = 1'b1;
        wait_pulse(0, 8, lat, oth);
        tick();
        note_done = 1'b1;
        song = 2'd2;
        wait_pulse(0, 8, lat, oth);
        checks++; if (lat != 3 || oth != 0) begin failures++; $display("FAIL t4_change_latency: got %0d/%0d want 3/0", lat, oth); end
        checks++; if (note_o !== 6'd30 || dur_o !== 6'd3) begin failures++; $display("FAIL t4_new_song_entry: got %0d/%0d want 30/3", note_o, dur_o); end
        for (int i = 1; i < 4; i++) begin
            tick();
            note_done = 1'b1;
            wait_pulse(0, 8, lat, oth);
            checks++; if (lat != 3 || note_o !== 6'(ref_note(2, i)) || dur_o !== 6'(ref_dur(2, i))) begin failures++; $display("FAIL t4_entry%0d: got lat %0d %0d/%0d want 3 %0d/%0d", i, lat, note_o, dur_o, ref_note(2, i), ref_dur(2, i)); end
        end
        tick();
        note_done = 1'b1;
        wait_pulse(1, 8, lat, oth);
        checks++; if (lat != 3 || oth != 0) begin failures++; $display("FAIL t4_done: got %0d/%0d want 3/0", lat, oth); end
        play = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_note_done_ignored();
        int lat, oth, seen;
        note_done = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (new_note || song_done || busy) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL t6_idle_reaction: got %0d want 0", seen); end
        checks++; if (note_o !== 6'd33 || dur_o !== 6'd2) begin failures++; $display("FAIL t6_idle_hold: got %0d/%0d want 33/2", note_o, dur_o); end
        song = 2'd2;
        play = 1'b1;
        tick();
        checks++; if (new_note !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL t6_fetch: got nn %0b busy %0b want 0/1", new_note, busy); end
        tick();
        checks++; if (new_note !== 1'b0) begin failures++; $display("FAIL t6_waitrom: got %0b want 0", new_note); end
        tick();
        checks++; if (new_note !== 1'b1 || note_o !== 6'd30) begin failures++; $display("FAIL t6_first_note: got %0b/%0d want 1/30", new_note, note_o); end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            note_done = 1'b0;
            if (new_note || song_done) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL t6_load_cycle_done: got %0d pulses want 0", seen); end
        note_done = 1'b1;
        wait_pulse(0, 8, lat, oth);
        checks++; if (lat != 3 || note_o !== 6'd31 || dur_o !== 6'd1) begin failures++; $display("FAIL t6_idx_kept: got lat %0d %0d/%0d want 3 31/1", lat, note_o, dur_o); end
        for (int i = 2; i < 4; i++) begin
            tick();
            note_done = 1'b1;
            wait_pulse(0, 8, lat, oth);
        end
        tick();
        note_done = 1'b1;
        wait_pulse(1, 8, lat, oth);
        checks++; if (lat != 3) begin failures++; $display("FAIL t6_done: got %0d want 3", lat); end
        play = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_long_song();
        int lat, oth, seen, bad;
        song = 2'd3;
        play = 1'b1;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            wait_pulse(0, 8, lat, oth);
            checks++;
            if (lat != 3 || oth != 0 || note_o !== 6'(ref_note(3, i)) || dur_o !== 6'(ref_dur(3, i))) begin
                failures++;
                $display("FAIL t5_entry%0d: got lat %0d %0d/%0d want 3 %0d/%0d", i, lat, note_o, dur_o, ref_note(3, i), ref_dur(3, i));
            end
            repeat ($urandom_range(1, 3)) tick();
            note_done = 1'b1;
        end
        wait_pulse(1, 8, lat, oth);
        checks++; if (lat != 1 || oth != 0) begin failures++; $display("FAIL t5_last_slot_done: got %0d/%0d want 1/0", lat, oth); end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (new_note || song_done || busy) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL t5_done_hold: got %0d want 0", seen); end
        play = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_song();
        int lat, oth;
        song = 2'd3;
        play = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_pulse(0, 8, lat, oth);
            if (i < 7) begin
                tick();
                note_done = 1'b1;
            end
        end
        checks++; if (note_o !== 6'd39 || dur_o !== 6'd4) begin failures++; $display("FAIL t1_at_idx7: got %0d/%0d want 39/4", note_o, dur_o); end
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (note_o !== 6'd0 || dur_o !== 6'd0) begin failures++; $display("FAIL t1_async_regs: got %0d/%0d want 0/0", note_o, dur_o); end
        checks++; if (new_note !== 1'b0 || song_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t1_async_flags: got %0b%0b%0b want 000", new_note, song_done, busy); end
        @(negedge clk);
        reset = 1'b0;
        wait_pulse(0, 8, lat, oth);
        checks++; if (lat != 3 || note_o !== 6'd32 || dur_o !== 6'd1) begin failures++; $display("FAIL t1_restart: got lat %0d %0d/%0d want 3 32/1", lat, note_o, dur_o); end
        reset = 1'b1;
        play  = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random_play();
        int lat, oth, s, i;
        bit fin;
        for (int n = 0; n < 6; n++) begin
            s = int'($urandom_range(0, 3));
            song = 2'(s);
            play = 1'b1;
            i = 0;
            fin = 1'b0;
            wait_pulse(0, 8, lat, oth);
            while (!fin) begin
                checks++;
                if (lat != 3 || note_o !== 6'(ref_note(s, i)) || dur_o !== 6'(ref_dur(s, i))) begin
                    failures++;
                    $display("FAIL rnd_s%0d_i%0d: got lat %0d %0d/%0d want 3 %0d/%0d", s, i, lat, note_o, dur_o, ref_note(s, i), ref_dur(s, i));
                end
                if ($urandom_range(0, 3) == 0) begin
                    play = 1'b0;
                    repeat ($urandom_range(2, 4)) tick();
                    play = 1'b1;
                    wait_pulse(0, 8, lat, oth);
                    checks++;
                    if (lat != 3 || note_o !== 6'(ref_note(s, i))) begin
                        failures++;
                        $display("FAIL rnd_resume_s%0d_i%0d: got lat %0d note %0d want 3 %0d", s, i, lat, note_o, ref_note(s, i));
                    end
                end
                repeat ($urandom_range(1, 3)) tick();
                note_done = 1'b1;
                i++;
                if (i == 32 || ref_dur(s, i) == 0) begin
                    wait_pulse(1, 8, lat, oth);
                    checks++;
                    if (lat != ((i == 32) ? 1 : 3) || oth != 0) begin
                        failures++;
                        $display("FAIL rnd_done_s%0d: got %0d/%0d want %0d/0", s, lat, oth, (i == 32) ? 1 : 3);
                    end
                    fin = 1'b1;
                end else begin
                    wait_pulse(0, 8, lat, oth);
                end
            end
            play = 1'b0;
            tick();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_two_note_song();
        test_pause_resume();
        test_song_change();
        test_note_done_ignored();
        test_long_song();
        test_reset_mid_song();
        test_random_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
